vga_pixel_queue: RTL and testbench
==================================

// Module: vga_pixel_queue
// PURPOSE
//  Buffering/clipping stage between a drawing engine (fillscreen, circle, etc.) and vga_adapter.
//  - Accepts plot requests over a valid/ready handshake.
//  - Discards coordinates outside the 160x120 screen and counts them.
//  - Queues the rest and replays them to vga_adapter at one plot per clock.
//  - Lets engines stall on backpressure instead of asserting plot blindly.
// PARAMETERS
//  DEPTH     16   FIFO entries; power of two, >=2
//  SCREEN_W  160  x must be < SCREEN_W to be plotted
//  SCREEN_H  120  y must be < SCREEN_H to be plotted
// PORTS
//  clk         in   1   system clock (CLOCK_50)
//  rst         in   1   asynchronous reset, active-high
//  in_valid    in   1   upstream has a pixel this cycle
//  in_ready    out  1   queue can take a pixel this cycle
//  in_x        in   8   pixel x
//  in_y        in   7   pixel y
//  in_colour   in   3   pixel colour
//  vga_x       out  8   to vga_adapter .x
//  vga_y       out  7   to vga_adapter .y
//  vga_colour  out  3   to vga_adapter .colour
//  vga_plot    out  1   to vga_adapter .plot, one-cycle pulse per pixel
//  idle        out  1   FIFO empty and vga_plot low (all pixels written)
//  clip_cnt    out  16  number of discarded out-of-range pixels, saturating
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - count, rd/wr pointers, clip_cnt, vga_x, vga_y, vga_colour and vga_plot all clear to 0.
//    - in_ready=0 and idle=1 while rst is high.
//    - FIFO contents are discarded; no plot is emitted for any entry queued before reset.
//  - Handshake:
//    - A transfer occurs on a rising edge where in_valid && in_ready.
//    - in_ready = !rst && (count < DEPTH). It is combinational from registered count and never depends on in_valid.
//    - Upstream holds in_x/in_y/in_colour stable while in_valid && !in_ready.
//  - Clipping:
//    - A transfer with in_x >= SCREEN_W or in_y >= SCREEN_H completes the handshake but is not queued.
//    - clip_cnt increments by 1 for each such transfer and saturates at 16'hFFFF.
//    - Boundary values: x=159,y=119 is kept; x=160 or y=120 is clipped; x=255,y=127 is clipped.
//  - Output:
//    - On each edge where count > 0, the head entry is popped into vga_x/vga_y/vga_colour and vga_plot=1 for the next cycle.
//    - Otherwise vga_plot=0 and vga_x/vga_y/vga_colour hold their last values.
//    - Latency: an accepted pixel pushed at edge N is popped at edge N+1; vga_plot is high during cycle N+1..N+2.
//    - Sustained throughput is 1 pixel/clk; a plot is never stalled (vga_adapter always accepts).
//  - Simultaneous push and pop:
//    - count stays unchanged.
//    - When count==DEPTH, in_ready=0 even though a pop occurs this cycle (no same-cycle refill).
//  - Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
//  - Ordering: pixels reach vga_* in acceptance order. Clipped pixels leave no gap cycle.
//  - idle = (count==0) && !vga_plot. Engines assert their done only after idle is seen.
// STRUCTURE
//  - Package vga_pkg:
//    - SCREEN_W and SCREEN_H localparams.
//    - typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] colour;} pixel_t (18 bits).
//  - Sub-module pixel_fifo #(DEPTH, pixel_t):
//    - Synchronous single-clock FIFO with push/pop/full/empty/count.
//    - Async active-high reset on pointers and count only; the storage array is not reset.
//  - Top level holds the clip comparator, clip_cnt, output registers and idle logic.
// TESTING
//  1. Reset: hold rst=1 mid-stream with 5 queued pixels, release -> vga_plot stays 0, idle=1, clip_cnt=0, in_ready=1 next cycle.
//  2. Single pixel (10,20,3'b101) at edge N -> vga_plot=1 exactly one cycle after edge N+1 with vga_x=10, vga_y=20, vga_colour=5; then idle=1.
//  3. Clipping: push (159,119),(160,0),(0,120),(255,127) -> only (159,119) plotted; clip_cnt=3; no gap cycle.
//  4. Backpressure: valid held high, 20 in-range pixels, DEPTH=16 -> 20 plots in order, count never exceeds 16.
//  5. Throughput: 19200 consecutive pixels of a full-screen sweep with in_valid always 1 -> 19200 plots, last plot within 2 cycles of last accept.
//  6. Saturation: force 65540 clipped transfers -> clip_cnt=16'hFFFF and holds; vga_plot never asserted.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// vga_pkg : screen geometry and pixel record for the VGA queue
// Rev 1.0
// ---------------------------------------------------------------
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ---------------------------------------------------------------
// pixel_fifo : single-clock FIFO, head visible combinationally
// Rev 1.0
// ---------------------------------------------------------------
module pixel_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [17:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == C_DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_queue.sv
`default_nettype none
// ---------------------------------------------------------------
// vga_pixel_queue : clip, queue and replay pixels to vga_adapter
// Rev 1.0
// ---------------------------------------------------------------
module vga_pixel_queue
  import vga_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        idle,
  output logic [15:0] clip_cnt
);

  pixel_t                  fifo_din;
  pixel_t                  fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    accept;
  logic                    in_range;

  assign accept   = in_valid && in_ready;
  assign in_range = (int'(in_x) < SCREEN_W) && (int'(in_y) < SCREEN_H);
  // Ready follows the registered fill level only, so a pop cannot free a slot in the same cycle.
  assign in_ready = !rst && !fifo_full;
  assign fifo_din = '{x: in_x, y: in_y, colour: in_colour};
  assign idle     = (fifo_count == '0) && !vga_plot;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && in_range),
    .pop   (!fifo_empty),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= !fifo_empty;
      if (!fifo_empty) begin
        vga_x      <= fifo_dout.x;
        vga_y      <= fifo_dout.y;
        vga_colour <= fifo_dout.colour;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if (accept && !in_range && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_queue.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_vga_pixel_queue : randomized and directed checks against a queue model
// Rev 1.0
// ---------------------------------------------------------------
module tb_vga_pixel_queue;

  localparam int DEPTH = 16;
  localparam int SW    = 160;
  localparam int SH    = 120;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        idle;
  logic [15:0] clip_cnt;

  vga_pixel_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .idle       (idle),
    .clip_cnt   (clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          n_plots;
  logic [17:0] q[$];
  logic [17:0] m_pix;
  bit          m_plot;
  logic [15:0] m_clip;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit on_screen(input logic [7:0] x, input logic [6:0] y);
    return (int'(x) < SW) && (int'(y) < SH);
  endfunction

  // Called just after a falling edge; drives inputs, advances one clock, checks outputs.
  task automatic step(input bit v, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bit acc;
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    in_colour = c;
    #1;
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < DEPTH)});
    acc = v && (q.size() < DEPTH);
    @(posedge clk);
    m_plot = (q.size() > 0);
    if (m_plot) m_pix = q.pop_front();
    if (acc) begin
      if (on_screen(x, y)) q.push_back({x, y, c});
      else if (m_clip != 16'hFFFF) m_clip++;
    end
    @(negedge clk);
    check_eq("vga_plot", {31'b0, vga_plot}, {31'b0, m_plot});
    check_eq("vga_pix", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, m_pix});
    check_eq("idle", {31'b0, idle}, {31'b0, (q.size() == 0) && !m_plot});
    check_eq("clip_cnt", {16'b0, clip_cnt}, {16'b0, m_clip});
    if (vga_plot) n_plots++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("rst_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_idle", {31'b0, idle}, 32'd1);
    check_eq("rst_plot", {31'b0, vga_plot}, 32'd0);
    check_eq("rst_clip", {16'b0, clip_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_pix  = '0;
    m_plot = 1'b0;
    m_clip = '0;
    #1;
    check_eq("post_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int plots0;
    n_checks  = 0;
    n_errors  = 0;
    n_plots   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_colour = '0;
    m_pix     = '0;
    m_plot    = 1'b0;
    m_clip    = '0;
    @(negedge clk);
    do_reset();

    // Mid-stream reset with traffic in flight, then one quiet cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 3), 7'(i + 7), 3'(i));
    do_reset();
    step(1'b0, 8'd0, 7'd0, 3'd0);
    check_eq("after_rst_plot", {31'b0, vga_plot}, 32'd0);
    check_eq("after_rst_clip", {16'b0, clip_cnt}, 32'd0);

    // Single pixel
    step(1'b1, 8'd10, 7'd20, 3'b101);
    step(1'b0, 8'd0, 7'd0, 3'd0);
    check_eq("single_plot", {31'b0, vga_plot}, 32'd1);
    check_eq("single_xyc", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, 8'd10, 7'd20, 3'd5});
    step(1'b0, 8'd0, 7'd0, 3'd0);
    check_eq("single_idle", {31'b0, idle}, 32'd1);

    // Clipping boundaries
    step(1'b1, 8'd159, 7'd119, 3'd1);
    step(1'b1, 8'd160, 7'd0,   3'd2);
    step(1'b1, 8'd0,   7'd120, 3'd3);
    step(1'b1, 8'd255, 7'd127, 3'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 7'd0, 3'd0);
    check_eq("clip_three", {16'b0, clip_cnt}, 32'd3);

    // Back-to-back in-range burst
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i * 7), 7'(i * 5), 3'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 7'd0, 3'd0);

    // Randomized traffic biased around the screen edges
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] rx;
      logic [6:0] ry;
      rx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(155, 165)) : 8'($urandom_range(0, 255));
      ry = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(115, 125)) : 7'($urandom_range(0, 127));
      step(($urandom_range(0, 3) != 0), rx, ry, 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 7'd0, 3'd0);

    // Full-screen sweep
    plots0 = n_plots;
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        step(1'b1, 8'(x), 7'(y), 3'(x + y));
    for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 7'd0, 3'd0);
    check_eq("sweep_plots", n_plots - plots0, 32'd19200);
    check_eq("sweep_idle", {31'b0, idle}, 32'd1);

    // Clip counter saturation
    do_reset();
    plots0 = n_plots;
    for (int i = 0; i < 65540; i++) step(1'b1, 8'd200, 7'($urandom_range(0, 127)), 3'd7);
    check_eq("sat_clip", {16'b0, clip_cnt}, 32'h0000FFFF);
    check_eq("sat_noplot", n_plots - plots0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
